radar_sweep_ctrl: RTL and testbench

Sequencer for the target-playback path of the radar simulator. Once `radar_statistics` reports `CALIBRATED`, it locks onto the antenna rotation:
- Each ARP starts a sweep.
- Each ACP advances the azimuth index and requests the next azimuth data block from the loader over a REQ/ACK handshake.
- Each TRIG releases a one-cycle playback strobe, but only if the current block has been acknowledged.

It sits between `radar_statistics`, the DMA/BRAM block loader and the range playback engine.

---
 rtl/radar_sweep_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_radar_sweep_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/radar_sweep_ctrl.sv
// radar_sweep_ctrl: locks target playback onto antenna rotation.
// ARP restarts a sweep, ACP steps the azimuth index and fetches the next
// azimuth block over a REQ/ACK handshake, TRIG releases a playback strobe
// once the current block is resident.
module radar_sweep_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  SYS_CLK,
    input  logic                  RESETN,
    input  logic                  ARP,
    input  logic                  ACP,
    input  logic                  TRIG,
    input  logic                  ENABLE,
    input  logic                  CALIBRATED,
    input  logic [DATA_WIDTH-1:0] ACP_CNT,
    output logic                  LOAD_REQ,
    output logic [ADDR_WIDTH-1:0] LOAD_ADDR,
    input  logic                  LOAD_ACK,
    output logic [ADDR_WIDTH-1:0] AZ_IDX,
    output logic                  SWEEP_START,
    output logic                  TRIG_OUT,
    output logic                  RUNNING,
    output logic [DATA_WIDTH-1:0] SWEEP_CNT,
    output logic [3:0]            STATUS
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_CAL = 3'd1;
    localparam logic [2:0] ST_WAIT_ARP = 3'd2;
    localparam logic [2:0] ST_RUN      = 3'd3;
    localparam logic [2:0] ST_STOP     = 3'd4;

    // Comparison width wide enough for ACP_CNT, AZ_IDX and 2^ADDR_WIDTH.
    localparam int CW = ((DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH) + 1;

    logic [2:0]            state, state_nxt;
    logic [2:0]            arp_sync, acp_sync, trig_sync;
    logic                  arp_evt, acp_evt, trig_evt;
    logic [CW-1:0]         acp_cnt_x, az_idx_x;
    logic                  cfg_ok, at_last;
    logic                  arp_take, acp_step, ovf_set, trig_fire, tmiss_set;
    logic                  cfg_set, lmiss_set, clr_stats;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic                  block_valid;
    logic                  pend_vld;
    logic [ADDR_WIDTH-1:0] pend_addr;
    logic                  cfg_err, acp_ovf, load_miss, trig_miss;

    // Rising-edge detection on the resynchronised pulses: bit1 is s2, bit2 is s3.
    assign arp_evt  = arp_sync[1]  & ~arp_sync[2];
    assign acp_evt  = acp_sync[1]  & ~acp_sync[2];
    assign trig_evt = trig_sync[1] & ~trig_sync[2];

    // ACP_CNT must lie in 1..2^ADDR_WIDTH so every index fits in AZ_IDX.
    assign acp_cnt_x = CW'(ACP_CNT);
    assign az_idx_x  = CW'(AZ_IDX);
    assign cfg_ok    = (acp_cnt_x != '0) && (acp_cnt_x <= (CW'(1) << ADDR_WIDTH));
    assign at_last   = ((az_idx_x + CW'(1)) == acp_cnt_x);

    assign STATUS = {cfg_err, acp_ovf, load_miss, trig_miss};

    // Two-stage synchroniser plus delay stage for each raw pulse input.
    always_ff @(posedge SYS_CLK or negedge RESETN) begin
        if (!RESETN) begin
            arp_sync  <= '0;
            acp_sync  <= '0;
            trig_sync <= '0;
        end else begin
            arp_sync  <= {arp_sync[1:0], ARP};
            acp_sync  <= {acp_sync[1:0], ACP};
            trig_sync <= {trig_sync[1:0], TRIG};
        end
    end

    // Next-state and per-cycle event decisions; ARP outranks a same-cycle ACP.
    always_comb begin
        state_nxt  = state;
        arp_take   = 1'b0;
        acp_step   = 1'b0;
        ovf_set    = 1'b0;
        trig_fire  = 1'b0;
        tmiss_set  = 1'b0;
        cfg_set    = 1'b0;
        clr_stats  = 1'b0;
        issue      = 1'b0;
        issue_addr = '0;
        case (state)
            ST_IDLE: begin
                if (ENABLE) begin
                    state_nxt = ST_WAIT_CAL;
                    clr_stats = 1'b1;
                end
            end
            ST_WAIT_CAL: begin
                if (!ENABLE) begin
                    state_nxt = ST_STOP;
                end else if (CALIBRATED) begin
                    if (cfg_ok) state_nxt = ST_WAIT_ARP;
                    else        cfg_set   = 1'b1;
                end
            end
            ST_WAIT_ARP: begin
                if (!ENABLE) begin
                    state_nxt = ST_STOP;
                end else if (arp_evt) begin
                    state_nxt = ST_RUN;
                    arp_take  = 1'b1;
                end
            end
            ST_RUN: begin
                if (!ENABLE) begin
                    state_nxt = ST_STOP;
                end else begin
                    if (arp_evt) begin
                        arp_take = 1'b1;
                    end else if (acp_evt) begin
                        if (at_last) ovf_set  = 1'b1;
                        else         acp_step = 1'b1;
                    end
                    if (trig_evt) begin
                        if (block_valid) trig_fire = 1'b1;
                        else             tmiss_set = 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (!LOAD_REQ) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (arp_take) begin
            issue      = 1'b1;
            issue_addr = '0;
        end else if (acp_step) begin
            issue      = 1'b1;
            issue_addr = AZ_IDX + ADDR_WIDTH'(1);
        end
        lmiss_set = issue & LOAD_REQ;
    end

    // Sequencer state, sweep bookkeeping, strobes and sticky status flags.
    always_ff @(posedge SYS_CLK or negedge RESETN) begin
        if (!RESETN) begin
            state       <= ST_IDLE;
            RUNNING     <= 1'b0;
            SWEEP_START <= 1'b0;
            TRIG_OUT    <= 1'b0;
            AZ_IDX      <= '0;
            SWEEP_CNT   <= '0;
            cfg_err     <= 1'b0;
            acp_ovf     <= 1'b0;
            load_miss   <= 1'b0;
            trig_miss   <= 1'b0;
        end else begin
            state       <= state_nxt;
            RUNNING     <= (state_nxt == ST_RUN);
            SWEEP_START <= arp_take;
            TRIG_OUT    <= trig_fire;
            if (arp_take)      AZ_IDX <= '0;
            else if (acp_step) AZ_IDX <= issue_addr;
            if (clr_stats) begin
                SWEEP_CNT <= '0;
                cfg_err   <= 1'b0;
                acp_ovf   <= 1'b0;
                load_miss <= 1'b0;
                trig_miss <= 1'b0;
            end else begin
                if (arp_take)  SWEEP_CNT <= SWEEP_CNT + DATA_WIDTH'(1);
                if (cfg_set)   cfg_err   <= 1'b1;
                if (ovf_set)   acp_ovf   <= 1'b1;
                if (lmiss_set) load_miss <= 1'b1;
                if (tmiss_set) trig_miss <= 1'b1;
            end
        end
    end

    // Loader handshake with a one-entry pending slot that keeps only the newest index.
    always_ff @(posedge SYS_CLK or negedge RESETN) begin
        if (!RESETN) begin
            LOAD_REQ    <= 1'b0;
            LOAD_ADDR   <= '0;
            block_valid <= 1'b0;
            pend_vld    <= 1'b0;
            pend_addr   <= '0;
        end else if (LOAD_REQ) begin
            if (issue) begin
                pend_vld  <= 1'b1;
                pend_addr <= issue_addr;
            end
            if (LOAD_ACK) begin
                LOAD_REQ    <= 1'b0;
                block_valid <= !(pend_vld || issue);
            end
        end else if (issue) begin
            LOAD_REQ    <= 1'b1;
            LOAD_ADDR   <= issue_addr;
            block_valid <= 1'b0;
            pend_vld    <= 1'b0;
        end else if (pend_vld && (state == ST_RUN)) begin
            LOAD_REQ  <= 1'b1;
            LOAD_ADDR <= pend_addr;
            pend_vld  <= 1'b0;
        end else if (state != ST_RUN) begin
            pend_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_radar_sweep_ctrl.sv
// Testbench for radar_sweep_ctrl: randomised pulse sequences checked against
// a transaction-level model of sweeps, azimuth steps, block loads and strobes.
module tb_radar_sweep_ctrl;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arp = 1'b0, acp = 1'b0, trig = 1'b0;
    logic        enable = 1'b0, calibrated = 1'b0;
    logic [31:0] acp_cnt = '0;
    logic        load_req, load_ack = 1'b0;
    logic [15:0] load_addr, az_idx;
    logic        sweep_start, trig_out, running;
    logic [31:0] sweep_cnt;
    logic [3:0]  status;

    radar_sweep_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
        .SYS_CLK(sys_clk), .RESETN(rst_n), .ARP(arp), .ACP(acp), .TRIG(trig),
        .ENABLE(enable), .CALIBRATED(calibrated), .ACP_CNT(acp_cnt),
        .LOAD_REQ(load_req), .LOAD_ADDR(load_addr), .LOAD_ACK(load_ack),
        .AZ_IDX(az_idx), .SWEEP_START(sweep_start), .TRIG_OUT(trig_out),
        .RUNNING(running), .SWEEP_CNT(sweep_cnt), .STATUS(status)
    );

    always #5 sys_clk = ~sys_clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Loader model: acknowledges each request ack_delay cycles after it rises.
    int ack_delay = 4;
    int ack_wait = 0;
    int ack_cnt = 0;
    always @(negedge sys_clk) begin
        if (load_ack) begin
            load_ack = 1'b0;
        end else if (rst_n && load_req) begin
            ack_wait = ack_wait + 1;
            if (ack_wait >= ack_delay) begin
                load_ack = 1'b1;
                ack_wait = 0;
                ack_cnt  = ack_cnt + 1;
            end
        end else begin
            ack_wait = 0;
        end
    end

    // Output monitor: request addresses and strobe counts.
    int   got_addr[$];
    logic req_prev = 1'b0;
    int   trig_seen = 0;
    int   ss_seen = 0;
    always @(negedge sys_clk) begin
        if (load_req && !req_prev) got_addr.push_back(int'(load_addr));
        req_prev = load_req;
        trig_seen += int'(trig_out);
        ss_seen   += int'(sweep_start);
    end

    // Reference model state.
    int exp_addr[$];
    int m_cnt = 0, m_az = 0, m_sweeps = 0, m_trig = 0, m_ss = 0;
    bit m_run = 0, m_armed = 0;
    bit m_cfg = 0, m_ovf = 0, m_lmiss = 0, m_tmiss = 0;
    bit m_busy = 0, m_has_pend = 0, m_valid = 0;
    int m_pend = 0;

    function automatic logic [3:0] m_status();
        return {m_cfg, m_ovf, m_lmiss, m_tmiss};
    endfunction

    task automatic expect_load(input int a);
        if (m_busy) begin
            m_lmiss    = 1;
            m_pend     = a;
            m_has_pend = 1;
        end else begin
            exp_addr.push_back(a);
            m_busy  = 1;
            m_valid = 0;
        end
    endtask

    task automatic model_ack();
        m_busy = 0;
        if (m_has_pend) begin
            exp_addr.push_back(m_pend);
            m_busy     = 1;
            m_has_pend = 0;
        end else begin
            m_valid = 1;
        end
    endtask

    task automatic model_clear();
        m_cfg = 0; m_ovf = 0; m_lmiss = 0; m_tmiss = 0; m_sweeps = 0;
    endtask

    task automatic pulse(input logic a, input logic c, input logic t);
        @(negedge sys_clk);
        arp = a; acp = c; trig = t;
        repeat (4) @(negedge sys_clk);
        arp = 1'b0; acp = 1'b0; trig = 1'b0;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic model_arp();
        if (m_run || m_armed) begin
            m_run = 1; m_armed = 0;
            m_az = 0;
            m_sweeps++;
            m_ss++;
            expect_load(0);
        end
    endtask

    task automatic ev_arp();  pulse(1'b1, 1'b0, 1'b0); model_arp(); endtask
    task automatic ev_both(); pulse(1'b1, 1'b1, 1'b0); model_arp(); endtask

    task automatic ev_acp();
        pulse(1'b0, 1'b1, 1'b0);
        if (m_run) begin
            if (m_az == m_cnt - 1) m_ovf = 1;
            else begin
                m_az++;
                expect_load(m_az);
            end
        end
    endtask

    task automatic ev_trig();
        pulse(1'b0, 1'b0, 1'b1);
        if (m_run) begin
            if (m_valid) m_trig++;
            else         m_tmiss = 1;
        end
    endtask

    // Let a fast loader finish everything outstanding.
    task automatic settle();
        repeat (ack_delay + 20) @(negedge sys_clk);
        while (m_busy) model_ack();
    endtask

    task automatic wait_ack(input int target);
        int t = 0;
        while (ack_cnt < target && t < 2000) begin
            @(negedge sys_clk);
            t++;
        end
        chk("ack_wait_expired", longint'(ack_cnt >= target), 1);
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic chk_state();
        chk("az_idx", az_idx, m_az);
        chk("sweep_cnt", sweep_cnt, m_sweeps);
        chk("running", running, m_run);
        chk("status", status, m_status());
        chk("trig_out_count", trig_seen, m_trig);
        chk("sweep_start_count", ss_seen, m_ss);
    endtask

    initial begin
        int k, base;
        ack_delay = $urandom_range(2, 10);
        repeat (3) @(negedge sys_clk);
        // Reset state
        chk("rst_load_req", load_req, 0);
        chk("rst_load_addr", load_addr, 0);
        chk("rst_trig_out", trig_out, 0);
        chk("rst_sweep_start", sweep_start, 0);
        chk_state();
        rst_n = 1'b1;

        // Nominal randomised run
        m_cnt = $urandom_range(3, 7);
        acp_cnt = 32'(m_cnt);
        calibrated = 1'b1;
        enable = 1'b1;
        repeat (6) @(negedge sys_clk);
        m_armed = 1;
        chk("armed_not_running", running, 0);
        ev_trig(); settle();
        ev_acp();  settle();
        chk_state();
        chk("no_req_before_arp", got_addr.size(), 0);
        for (int s = 0; s < 4; s++) begin
            if (s == 0)      k = m_cnt - 1;
            else if (s == 1) k = $urandom_range(0, m_cnt - 1);
            else if (s == 2) k = m_cnt + $urandom_range(1, 2);
            else             k = 1;
            ev_arp(); settle();
            ev_trig(); settle();
            for (int i = 0; i < k; i++) begin
                ev_acp(); settle();
                if ($urandom_range(0, 1) == 1) begin
                    ev_trig(); settle();
                end
            end
            chk_state();
        end

        // Coincident ARP and ACP
        base = got_addr.size();
        ev_both(); settle();
        chk_state();
        chk("coincident_single_req", got_addr.size(), base + 1);
        chk("coincident_addr", load_addr, 0);

        // Stop while a request is outstanding
        ack_delay = 200;
        base = ack_cnt;
        ev_acp();
        enable = 1'b0;
        repeat (5) @(negedge sys_clk);
        m_run = 0;
        chk("stop_running", running, 0);
        chk("stop_req_held", load_req, 1);
        wait_ack(base + 1);
        model_ack();
        chk("stop_req_dropped", load_req, 0);
        ack_delay = 4;

        // Restart with configuration errors, then the 2^16 boundary
        calibrated = 1'b0;
        acp_cnt = 32'd5;
        enable = 1'b1;
        repeat (6) @(negedge sys_clk);
        model_clear();
        chk_state();
        acp_cnt = 32'd0;
        calibrated = 1'b1;
        repeat (6) @(negedge sys_clk);
        m_cfg = 1;
        chk_state();
        acp_cnt = 32'd65537;
        repeat (6) @(negedge sys_clk);
        chk_state();
        m_cnt = 65536;
        acp_cnt = 32'd65536;
        repeat (6) @(negedge sys_clk);
        m_armed = 1;
        ev_trig(); settle();
        chk_state();
        ev_arp(); settle();
        chk_state();

        // Slow loader: miss on busy loader, pending keeps only the newest index
        ack_delay = 300;
        base = ack_cnt;
        ev_acp();
        repeat (10) @(negedge sys_clk);
        ev_trig();
        ev_acp();
        ev_acp();
        chk_state();
        chk("slow_first_addr", load_addr, 1);
        wait_ack(base + 1);
        model_ack();
        chk("slow_reissue_req", load_req, 1);
        chk("slow_reissue_addr", load_addr, 3);
        wait_ack(base + 2);
        model_ack();
        ack_delay = 4;
        ev_trig(); settle();
        chk_state();

        // Asynchronous reset in the middle of a handshake
        ack_delay = 200;
        ev_acp();
        @(posedge sys_clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_load_req", load_req, 0);
        chk("arst_load_addr", load_addr, 0);
        chk("arst_az_idx", az_idx, 0);
        chk("arst_sweep_cnt", sweep_cnt, 0);
        chk("arst_running", running, 0);
        chk("arst_status", status, 0);
        m_az = 0; m_run = 0; m_armed = 0; m_busy = 0; m_has_pend = 0; m_valid = 0;
        model_clear();
        repeat (4) @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (4) @(negedge sys_clk);
        chk_state();

        // Full request address history
        chk("req_count", got_addr.size(), exp_addr.size());
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
            chk("req_addr", got_addr[i], exp_addr[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
